// File: rtl/id_ex_latch_pkg.sv
// Shared widths, opcodes and the ID/EX bundle type.
// Imported by the ID/EX latch, the EX stage and the debug unit.
package id_ex_latch_pkg;

    localparam int NB_DATA       = 32;
    localparam int NB_REG        = 5;
    localparam int NB_OPCODE     = 6;
    localparam int NB_FUNCT      = 6;
    localparam int NB_BUBBLE_CNT = 16;

    localparam logic [NB_OPCODE-1:0] R_instruc = 6'b000000;
    localparam logic [NB_OPCODE-1:0] J_instruc = 6'b000010;
    localparam logic [NB_OPCODE-1:0] JAL_instruc = 6'b000011;
    localparam logic [NB_OPCODE-1:0] BEQ_instruc = 6'b000100;
    localparam logic [NB_OPCODE-1:0] BNE_instruc = 6'b000101;
    localparam logic [NB_OPCODE-1:0] ADDI_instruc = 6'b001000;
    localparam logic [NB_OPCODE-1:0] ADDIU_instruc = 6'b001001;
    localparam logic [NB_OPCODE-1:0] SLTI_instruc = 6'b001010;
    localparam logic [NB_OPCODE-1:0] SLTIU_instruc = 6'b001011;
    localparam logic [NB_OPCODE-1:0] ANDI_instruc = 6'b001100;
    localparam logic [NB_OPCODE-1:0] ORI_instruc = 6'b001101;
    localparam logic [NB_OPCODE-1:0] XORI_instruc = 6'b001110;
    localparam logic [NB_OPCODE-1:0] LUI_instruc = 6'b001111;
    localparam logic [NB_OPCODE-1:0] LB_instruc = 6'b100000;
    localparam logic [NB_OPCODE-1:0] LH_instruc = 6'b100001;
    localparam logic [NB_OPCODE-1:0] LW_instruc = 6'b100011;
    localparam logic [NB_OPCODE-1:0] LBU_instruc = 6'b100100;
    localparam logic [NB_OPCODE-1:0] LHU_instruc = 6'b100101;
    localparam logic [NB_OPCODE-1:0] LWU_instruc = 6'b100111;
    localparam logic [NB_OPCODE-1:0] SB_instruc = 6'b101000;
    localparam logic [NB_OPCODE-1:0] SH_instruc = 6'b101001;
    localparam logic [NB_OPCODE-1:0] SW_instruc = 6'b101011;

    typedef struct packed {
        logic                 valid;
        logic                 signal_control_mult_A;
        logic                 signal_control_mult_B;
        logic [NB_OPCODE-1:0] opcode;
        logic [NB_FUNCT-1:0]  funct;
        logic [NB_REG-1:0]    rs_addr;
        logic [NB_REG-1:0]    rt_addr;
        logic [NB_REG-1:0]    rd_addr;
        logic [NB_DATA-1:0]   rs_data;
        logic [NB_DATA-1:0]   rt_data;
        logic [NB_DATA-1:0]   imm_ext;
        logic [NB_DATA-1:0]   pc_plus4;
    } id_ex_bundle;

    // A bubble is all zeros: invalid, selects low, writeback to $zero.
    function automatic id_ex_bundle id_ex_bubble();
        return '0;
    endfunction

endpackage

// File: rtl/id_ex_latch_if.sv
// ID-side and EX-side signal bundle of the ID/EX latch.
// master = ID/control side, slave = the latch itself.
interface id_ex_latch_if;
    import id_ex_latch_pkg::*;

    logic                     i_enable;
    logic                     i_hold;
    logic                     i_flush;
    logic                     i_valid;
    logic                     i_signal_control_mult_A;
    logic                     i_signal_control_mult_B;
    logic [NB_OPCODE-1:0]     i_opcode;
    logic [NB_FUNCT-1:0]      i_funct;
    logic [NB_REG-1:0]        i_rs_addr;
    logic [NB_REG-1:0]        i_rt_addr;
    logic [NB_REG-1:0]        i_rd_addr;
    logic [NB_DATA-1:0]       i_rs_data;
    logic [NB_DATA-1:0]       i_rt_data;
    logic [NB_DATA-1:0]       i_imm_ext;
    logic [NB_DATA-1:0]       i_pc_plus4;

    logic                     o_valid;
    logic                     o_signal_control_mult_A;
    logic                     o_signal_control_mult_B;
    logic [NB_OPCODE-1:0]     o_opcode;
    logic [NB_FUNCT-1:0]      o_funct;
    logic [NB_REG-1:0]        o_rs_addr;
    logic [NB_REG-1:0]        o_rt_addr;
    logic [NB_REG-1:0]        o_rd_addr;
    logic [NB_DATA-1:0]       o_rs_data;
    logic [NB_DATA-1:0]       o_rt_data;
    logic [NB_DATA-1:0]       o_imm_ext;
    logic [NB_DATA-1:0]       o_pc_plus4;
    logic [NB_BUBBLE_CNT-1:0] o_bubble_count;

    modport master (
        output i_enable, i_hold, i_flush, i_valid,
        output i_signal_control_mult_A, i_signal_control_mult_B,
        output i_opcode, i_funct,
        output i_rs_addr, i_rt_addr, i_rd_addr,
        output i_rs_data, i_rt_data, i_imm_ext, i_pc_plus4,
        input  o_valid,
        input  o_signal_control_mult_A, o_signal_control_mult_B,
        input  o_opcode, o_funct,
        input  o_rs_addr, o_rt_addr, o_rd_addr,
        input  o_rs_data, o_rt_data, o_imm_ext, o_pc_plus4,
        input  o_bubble_count
    );

    modport slave (
        input  i_enable, i_hold, i_flush, i_valid,
        input  i_signal_control_mult_A, i_signal_control_mult_B,
        input  i_opcode, i_funct,
        input  i_rs_addr, i_rt_addr, i_rd_addr,
        input  i_rs_data, i_rt_data, i_imm_ext, i_pc_plus4,
        output o_valid,
        output o_signal_control_mult_A, o_signal_control_mult_B,
        output o_opcode, o_funct,
        output o_rs_addr, o_rt_addr, o_rd_addr,
        output o_rs_data, o_rt_data, o_imm_ext, o_pc_plus4,
        output o_bubble_count
    );

endinterface

// File: rtl/id_ex_latch_sat_counter.sv
// Saturating up-counter; sticks at all-ones, cleared only by reset.
// Used to count bubbles injected into EX.
module sat_counter #(
    parameter int NB = 16
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_enable,
    input  logic          i_inc,
    output logic [NB-1:0] o_count
);

    logic at_max;

    assign at_max = &o_count;

    // Count up on qualified increments until all-ones.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_count <= '0;
        end else if (i_enable && i_inc && !at_max) begin
            o_count <= o_count + 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with hold, flush and debug enable.
// Bubbles are all-zero bundles; EX qualifies on o_valid only.
module id_ex_latch
    import id_ex_latch_pkg::*;
(
    input  logic         i_clock,
    input  logic         i_reset,
    id_ex_latch_if.slave bus
);

    id_ex_bundle id_data;
    id_ex_bundle ex_q;
    id_ex_bundle next_q;
    logic        load;
    logic        load_bubble;

    // Flush beats hold; an idle ID slot also loads a bubble.
    assign load = bus.i_enable && (bus.i_flush || !bus.i_hold);
    assign load_bubble = load && (bus.i_flush || !bus.i_valid);

    // Pack the ID-side inputs into one bundle.
    always_comb begin
        id_data                       = '0;
        id_data.valid                 = 1'b1;
        id_data.signal_control_mult_A = bus.i_signal_control_mult_A;
        id_data.signal_control_mult_B = bus.i_signal_control_mult_B;
        id_data.opcode                = bus.i_opcode;
        id_data.funct                 = bus.i_funct;
        id_data.rs_addr               = bus.i_rs_addr;
        id_data.rt_addr               = bus.i_rt_addr;
        id_data.rd_addr               = bus.i_rd_addr;
        id_data.rs_data               = bus.i_rs_data;
        id_data.rt_data               = bus.i_rt_data;
        id_data.imm_ext               = bus.i_imm_ext;
        id_data.pc_plus4              = bus.i_pc_plus4;
    end

    // Select the value to load: bubble or the ID bundle.
    always_comb begin
        next_q = id_data;
        if (load_bubble) begin
            next_q = id_ex_bubble();
        end
    end

    // Pipeline register; frozen when not loading.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            ex_q <= '0;
        end else if (load) begin
            ex_q <= next_q;
        end
    end

    sat_counter #(
        .NB (NB_BUBBLE_CNT)
    ) u_bubble_cnt (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_enable (bus.i_enable),
        .i_inc    (load_bubble),
        .o_count  (bus.o_bubble_count)
    );

    assign bus.o_valid                 = ex_q.valid;
    assign bus.o_signal_control_mult_A = ex_q.signal_control_mult_A;
    assign bus.o_signal_control_mult_B = ex_q.signal_control_mult_B;
    assign bus.o_opcode                = ex_q.opcode;
    assign bus.o_funct                 = ex_q.funct;
    assign bus.o_rs_addr               = ex_q.rs_addr;
    assign bus.o_rt_addr               = ex_q.rt_addr;
    assign bus.o_rd_addr               = ex_q.rd_addr;
    assign bus.o_rs_data               = ex_q.rs_data;
    assign bus.o_rt_data               = ex_q.rt_data;
    assign bus.o_imm_ext               = ex_q.imm_ext;
    assign bus.o_pc_plus4              = ex_q.pc_plus4;

endmodule

// File: tb/tb_id_ex_latch.sv
// Directed bench for the ID/EX latch.
// Inputs change 1 time unit after the rising edge; outputs sampled there too.
module tb_id_ex_latch;
    import id_ex_latch_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic wrapped;

    id_ex_latch_if bus ();

    id_ex_latch dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic ma, input logic mb,
                         input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] rsd,
                         input logic [31:0] rtd, input logic [31:0] imm,
                         input logic [31:0] pc);
        bus.i_valid = v;
        bus.i_signal_control_mult_A = ma;
        bus.i_signal_control_mult_B = mb;
        bus.i_opcode = op;
        bus.i_funct = fn;
        bus.i_rs_addr = rs;
        bus.i_rt_addr = rt;
        bus.i_rd_addr = rd;
        bus.i_rs_data = rsd;
        bus.i_rt_data = rtd;
        bus.i_imm_ext = imm;
        bus.i_pc_plus4 = pc;
    endtask

    initial begin
        total = 0;
        bad = 0;
        wrapped = 1'b0;
        rst_n = 1'b0;
        bus.i_enable = 1'b1;
        bus.i_hold = 1'b0;
        bus.i_flush = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 6'h23, 6'h21, 5'd1, 5'd2, 5'd3,
              32'hAAAA_5555, 32'h1111_2222, 32'hFFFF_FFF0, 32'h0000_0040);
        #3;
        check("rst_valid", 64'(bus.o_valid), 64'd0);
        check("rst_opcode", 64'(bus.o_opcode), 64'd0);
        check("rst_rs_data", 64'(bus.o_rs_data), 64'd0);
        check("rst_rd", 64'(bus.o_rd_addr), 64'd0);
        check("rst_count", 64'(bus.o_bubble_count), 64'd0);
        step();
        step();
        check("rst_held_valid", 64'(bus.o_valid), 64'd0);
        check("rst_held_multA", 64'(bus.o_signal_control_mult_A), 64'd0);
        check("rst_held_pc", 64'(bus.o_pc_plus4), 64'd0);

        // release reset, set up the normal capture vector
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 6'h00, 6'h20, 5'd3, 5'd4, 5'd9,
              32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_0010, 32'h0000_0104);
        #2;
        check("pre_edge_valid", 64'(bus.o_valid), 64'd0);
        step();
        check("cap_valid", 64'(bus.o_valid), 64'd1);
        check("cap_multA", 64'(bus.o_signal_control_mult_A), 64'd1);
        check("cap_multB", 64'(bus.o_signal_control_mult_B), 64'd1);
        check("cap_opcode", 64'(bus.o_opcode), 64'd0);
        check("cap_funct", 64'(bus.o_funct), 64'h20);
        check("cap_rs", 64'(bus.o_rs_addr), 64'd3);
        check("cap_rt", 64'(bus.o_rt_addr), 64'd4);
        check("cap_rd", 64'(bus.o_rd_addr), 64'd9);
        check("cap_rs_data", 64'(bus.o_rs_data), 64'h1234);
        check("cap_rt_data", 64'(bus.o_rt_data), 64'hDEAD_BEEF);
        check("cap_imm", 64'(bus.o_imm_ext), 64'h10);
        check("cap_pc", 64'(bus.o_pc_plus4), 64'h104);
        check("cap_count", 64'(bus.o_bubble_count), 64'd0);

        // capture a load, then stall it for 3 cycles
        drive(1'b1, 1'b0, 1'b1, 6'h23, 6'h00, 5'd5, 5'd7, 5'd7,
              32'h0000_0100, 32'h0, 32'h0000_0008, 32'h0000_0108);
        step();
        check("ld_rd", 64'(bus.o_rd_addr), 64'd7);
        check("ld_opcode", 64'(bus.o_opcode), 64'h23);
        bus.i_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 6'(i + 8), 6'h3F, 5'd31, 5'd30,
                  5'(20 + i), 32'hCAFE_0000 + 32'(i), 32'h5, 32'h6,
                  32'h7);
            step();
            check("hold_rd", 64'(bus.o_rd_addr), 64'd7);
            check("hold_opcode", 64'(bus.o_opcode), 64'h23);
            check("hold_rs_data", 64'(bus.o_rs_data), 64'h100);
            check("hold_count", 64'(bus.o_bubble_count), 64'd0);
        end
        bus.i_flush = 1'b1;
        step();
        check("flush_valid", 64'(bus.o_valid), 64'd0);
        check("flush_multA", 64'(bus.o_signal_control_mult_A), 64'd0);
        check("flush_multB", 64'(bus.o_signal_control_mult_B), 64'd0);
        check("flush_rd", 64'(bus.o_rd_addr), 64'd0);
        check("flush_rs_data", 64'(bus.o_rs_data), 64'd0);
        check("flush_pc", 64'(bus.o_pc_plus4), 64'd0);
        check("flush_count", 64'(bus.o_bubble_count), 64'd1);

        // ID slot empty: bubble via i_valid=0
        bus.i_flush = 1'b0;
        bus.i_hold = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 6'h08, 6'h01, 5'd1, 5'd2, 5'd3,
              32'h9, 32'h9, 32'h9, 32'h9);
        step();
        check("novalid_valid", 64'(bus.o_valid), 64'd0);
        check("novalid_rd", 64'(bus.o_rd_addr), 64'd0);
        check("novalid_imm", 64'(bus.o_imm_ext), 64'd0);
        check("novalid_count", 64'(bus.o_bubble_count), 64'd2);

        // debug freeze with a pending flush
        drive(1'b1, 1'b1, 1'b0, 6'h08, 6'h00, 5'd2, 5'd12, 5'd12,
              32'h77, 32'h0, 32'h44, 32'h200);
        step();
        check("pre_freeze_rd", 64'(bus.o_rd_addr), 64'd12);
        bus.i_enable = 1'b0;
        bus.i_flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("freeze_valid", 64'(bus.o_valid), 64'd1);
            check("freeze_rd", 64'(bus.o_rd_addr), 64'd12);
            check("freeze_count", 64'(bus.o_bubble_count), 64'd2);
        end
        bus.i_enable = 1'b1;
        step();
        check("unfreeze_valid", 64'(bus.o_valid), 64'd0);
        check("unfreeze_rd", 64'(bus.o_rd_addr), 64'd0);
        check("unfreeze_count", 64'(bus.o_bubble_count), 64'd3);

        // saturation: 65539 more bubbles, count starts at 3
        for (int i = 0; i < 65531; i++) begin
            step();
            if (bus.o_bubble_count == '0) wrapped = 1'b1;
        end
        check("sat_near", 64'(bus.o_bubble_count), 64'hFFFE);
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.o_bubble_count == '0) wrapped = 1'b1;
        end
        check("sat_top", 64'(bus.o_bubble_count), 64'hFFFF);
        check("sat_nowrap", 64'(wrapped), 64'd0);

        // async reset between edges while EX holds a real instruction
        bus.i_flush = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 6'h2B, 6'h00, 5'd8, 5'd9, 5'd10,
              32'h1, 32'h2, 32'h3, 32'h4);
        step();
        check("pre_arst_valid", 64'(bus.o_valid), 64'd1);
        check("pre_arst_rd", 64'(bus.o_rd_addr), 64'd10);
        bus.i_hold = 1'b1;
        bus.i_flush = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(bus.o_valid), 64'd0);
        check("arst_rd", 64'(bus.o_rd_addr), 64'd0);
        check("arst_pc", 64'(bus.o_pc_plus4), 64'd0);
        check("arst_count", 64'(bus.o_bubble_count), 64'd0);
        step();
        rst_n = 1'b1;
        bus.i_hold = 1'b0;
        bus.i_flush = 1'b0;
        step();
        check("post_arst_valid", 64'(bus.o_valid), 64'd1);
        check("post_arst_count", 64'(bus.o_bubble_count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_latch.md
Name: id_ex_latch

Overview:
- Pipeline register between the ID stage (decode/control, register file read) and the EX stage of the MIPS core.
- Captures the ID control mux selects, the decoded instruction fields, the operand data and PC+4 on each enabled clock edge.
- Supports hold (stall), flush (bubble insertion for load-use and branch hazards) and the debug-unit run/step enable.
- Keeps a saturating count of bubbles injected into EX, read by the debug unit.

Parameters:
NB_DATA, 32, width of operand data, immediate and PC fields
NB_REG, 5, register address width
NB_OPCODE, 6, opcode field width
NB_FUNCT, 6, funct field width
NB_BUBBLE_CNT, 16, bubble counter width

Ports:
i_clock  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_enable  in  1  debug-unit run/step enable; 0 freezes all state
i_hold  in  1  keep current contents (downstream stall)
i_flush  in  1  load a bubble instead of ID data
i_valid  in  1  ID holds a real instruction
i_signal_control_mult_A  in  1  ALU operand-A mux select from ID control
i_signal_control_mult_B  in  1  ALU operand-B mux select from ID control
i_opcode  in  NB_OPCODE  instruction opcode
i_funct  in  NB_FUNCT  instruction funct field
i_rs_addr / i_rt_addr / i_rd_addr  in  NB_REG  register addresses
i_rs_data / i_rt_data  in  NB_DATA  register-file read data
i_imm_ext  in  NB_DATA  sign-extended immediate
i_pc_plus4  in  NB_DATA  PC+4 of the instruction
o_<each field above>  out  same widths  registered copies, named o_signal_control_mult_A, o_opcode, and so on
o_valid  out  1  EX holds a real instruction
o_bubble_count  out  NB_BUBBLE_CNT  saturating count of bubbles loaded

Behaviour:
- Reset: i_reset=0 asynchronously clears every output and the counter to 0, including o_valid=0. All state is at 0 on the first edge after release.
- Latency: a captured field appears on the outputs 1 cycle after the capturing edge. No combinational path exists from inputs to outputs.
- Per-edge priority when i_reset=1:
  1) i_enable=0: all state holds, counter unchanged.
  2) i_flush=1: load a bubble. Flush wins over i_hold.
  3) i_hold=1: all state holds, counter unchanged.
  4) Otherwise: capture.
- Capture:
  - i_valid=1: every field is loaded from its input and o_valid=1.
  - i_valid=0: load a bubble instead.
- Bubble:
  - o_valid=0; both mult selects=0.
  - Opcode, funct, all addresses, data, immediate and PC fields=0. o_rd_addr=0, so any writeback targets $zero.
  - Bubble opcode 0 is the R-type code. EX must qualify on o_valid, never on the opcode.
- Bubble counter:
  - Increments by 1 on every edge that loads a bubble.
  - Saturates at all-ones and never wraps.
  - Only reset clears it.
- Simultaneous i_flush=1, i_hold=1, i_enable=1: bubble loaded, counter increments.
- i_enable deasserted mid-stall or mid-flush: state frozen. The pending action takes effect on the first edge with i_enable=1, provided the inputs are still asserted.
- Reset asserted mid-operation: immediate clear regardless of i_enable, i_hold or i_flush.

Decomposition:
- Shared package:
  - Width constants NB_DATA, NB_REG, NB_OPCODE, NB_FUNCT.
  - Opcode localparams: R_instruc=6'b000000 plus the I/J opcodes.
  - A packed id_ex_bundle typedef grouping control and data fields, reused by the EX stage and the debug unit.
- One natural sub-module: sat_counter (parameter NB, ports i_clock, i_reset, i_enable, i_inc, o_count), used for the bubble counter.

Test Plan:
- Reset: hold i_reset=0 with all inputs at non-zero values -> all outputs 0, o_bubble_count=0. Outputs stay 0 until the first edge after release.
- Normal capture: i_valid=1, i_signal_control_mult_A=1, i_signal_control_mult_B=1, i_opcode=0, i_rs_data=32'h0000_1234, i_rd_addr=5'd9 -> next cycle the outputs match exactly and o_valid=1.
- Hold then flush: capture an instruction with i_rd_addr=5'd7, then hold for 3 cycles with changing inputs -> outputs unchanged. Then assert i_flush=1 together with i_hold=1 -> o_valid=0, selects 0, o_rd_addr=0, o_bubble_count=1.
- Debug freeze: i_enable=0 for 5 cycles with i_flush=1 -> no change and counter unchanged. Raise i_enable with i_flush still 1 -> bubble loaded on that edge, counter +1.
- Saturation: force 2^NB_BUBBLE_CNT+3 bubbles -> o_bubble_count stays at 16'hFFFF and never wraps to 0.
- Asynchronous reset mid-stream: pulse i_reset=0 between edges while o_valid=1 -> outputs clear immediately, before the next clock edge.
